fifo_ctrl: RTL

Pointer and flag controller that turns the team's 2^ADDR_WIDTH-entry register file into a circular FIFO. It generates the write address, write enable and read address for the register file and tracks occupancy with full, empty and count outputs. It also flags overflow and underflow attempts. It is instantiated next to the register file inside the UART/IO buffer wrappers, and the register file read data is the FIFO head.

---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO pointer/flag controller.
// Op encoding is {write accepted, read accepted}; the bench scoreboard uses the same values.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_RD  = 2'b01,
      OP_WR  = 2'b10,
      OP_RW  = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e make_op(input logic do_wr, input logic do_rd);
      return fifo_op_e'({do_wr, do_rd});
   endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Circular-FIFO pointer and flag controller for a 2**ADDR_WIDTH-entry register file.
// Read is zero-latency: the register file output at r_addr is always the FIFO head.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0]   CountFull = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CountOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PtrOne    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic     do_wr, do_rd;
   fifo_op_e op;

   // A write into a full FIFO is still legal when a read frees a slot on the same edge.
   assign do_wr = wr & (~full_q | rd);
   assign do_rd = rd & ~empty_q;
   assign op    = make_op(do_wr, do_rd);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      full_d      = full_q;
      empty_d     = empty_q;
      overflow_d  = wr & full_q & ~rd;
      underflow_d = rd & empty_q;

      unique case (op)
         OP_NOP: ;
         OP_WR: begin
            wr_ptr_d = wr_ptr_q + PtrOne;
            count_d  = count_q + CountOne;
            empty_d  = 1'b0;
            full_d   = (count_q + CountOne) == CountFull;
         end
         OP_RD: begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            count_d  = count_q - CountOne;
            full_d   = 1'b0;
            empty_d  = (count_q - CountOne) == '0;
         end
         OP_RW: begin
            wr_ptr_d = wr_ptr_q + PtrOne;
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Gate with reset so the register file sees no write while reset is held.
   assign wr_en     = do_wr & ~reset;
   assign w_addr    = wr_ptr_q;
   assign r_addr    = rd_ptr_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
